bp_cacc_vdp_mac_stream: RTL and testbench
=========================================

// Module: bp_cacc_vdp_mac_stream
// PURPOSE
//  Streaming multiply-accumulate engine for the vector dot-product accelerator.
//  Consumes element pairs (a[i], b[i]) produced by the accelerator's D$ load sequencer.
//  Accumulates sum(a[i]*b[i]) over a programmed length with no 8-element limit.
//  Returns one result per job to the writeback/store stage.
// PARAMETERS
//  data_width_p   64  element and result width; arithmetic is modulo 2^data_width_p
//  len_width_p    16  width of the job element count
// PORTS
//  clk_i          in   1             clock
//  reset_i        in   1             synchronous, active-high reset
//  start_v_i      in   1             job start strobe; accepted only when start_ready_o=1
//  start_len_i    in   len_width_p   number of element pairs in the job
//  start_ready_o  out  1             1 only in IDLE
//  elem_v_i       in   1             element pair valid
//  elem_a_i       in   data_width_p  operand a[i]
//  elem_b_i       in   data_width_p  operand b[i]
//  elem_ready_o   out  1             1 in ACCUM while remaining count > 0
//  res_v_o        out  1             result valid; held until res_yumi_i
//  res_o          out  data_width_p  dot-product result
//  res_yumi_i     in   1             consumer takes result; legal only when res_v_o=1
//  busy_o         out  1             1 in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all counters and the accumulator cleared.
//   Output reset values: start_ready_o=1, elem_ready_o=0, res_v_o=0, res_o=0, busy_o=0.
//  Interface rules:
//   Element transfer occurs on elem_v_i & elem_ready_o (valid/ready).
//   Start transfer occurs on start_v_i & start_ready_o.
//  States:
//   IDLE -> ACCUM on start transfer with len!=0; latch remaining=len, clear acc.
//   IDLE -> DONE on start transfer with len==0; res_o=0, res_v_o=1 next cycle.
//   ACCUM: each element transfer decrements remaining.
//     The product a*b (low data_width_p bits) is registered in the mul stage.
//     The mul stage is added to acc one cycle later.
//     After the last transfer (remaining 1->0), elem_ready_o drops next cycle -> DRAIN.
//   DRAIN: wait until the mul stage valid is empty.
//     The final add completes, then -> DONE with res_o=acc.
//   DONE: res_v_o=1; res_o stable.
//     On res_yumi_i -> IDLE; start_ready_o=1 the following cycle.
//  Latency: last element transfer in cycle t -> res_v_o=1 in cycle t+3.
//  Throughput: one element pair per cycle with no bubbles; back-to-back pairs are required to work.
//  Arithmetic: unsigned; product truncated to data_width_p bits; accumulator wraps mod 2^data_width_p.
//  Simultaneous events:
//   start_v_i outside IDLE is ignored (no latch, no error).
//   elem_v_i outside ACCUM is ignored.
//   elem_v_i with remaining==0 is not accepted.
//  Reset mid-job: reset_i in any state aborts the job and returns to the reset values next cycle.
//   The partial accumulator is discarded.
//  len_width_p max (all ones) must work without counter overflow.
// STRUCTURE
//  bp_cacc_pkg (shared with bp_cacc_vdp):
//   state enum bp_cacc_mac_state_e {e_mac_idle, e_mac_accum, e_mac_drain, e_mac_done}
//   CSR offset constants for the accelerator register map.
//  Sub-module bp_cacc_mac_pipe: registered multiply stage plus accumulator (v/data in, acc out, clear).
//   The top holds the FSM and the element counter only.
// TESTING
//  1. len=3, a={1,2,3}, b={4,5,6} back-to-back -> res_o=32 three cycles after last pair.
//  2. len=0 start -> res_v_o=1 next cycle, res_o=0, elem_ready_o stays 0.
//  3. len=4, a=b=64'hFFFF_FFFF_FFFF_FFFF -> res_o=64'h4 (truncated product 1, summed).
//  4. len=5 with random elem_v_i gaps; res_yumi_i held low 10 cycles -> res_o=sum, res_v_o stable.
//     The 6th pair is not accepted.
//  5. start_v_i pulsed during ACCUM with len=9 -> ignored; original len=2 job result unchanged.
//  6. reset_i asserted after 2 of 4 pairs, then a new len=1 job a=7,b=6 -> res_o=42.

Source files
------------

// File: rtl/bp_cacc_pkg.sv
// Shared definitions for the vector dot-product accelerator: MAC stream state
// encoding and the accelerator CSR register map.
package bp_cacc_pkg;

  typedef enum logic [1:0] {
    e_mac_idle  = 2'd0,
    e_mac_accum = 2'd1,
    e_mac_drain = 2'd2,
    e_mac_done  = 2'd3
  } bp_cacc_mac_state_e;

  // Byte offsets of the accelerator register map.
  localparam logic [19:0] csr_ctrl_offset_gp     = 20'h0_0000;
  localparam logic [19:0] csr_len_offset_gp      = 20'h0_0008;
  localparam logic [19:0] csr_a_addr_offset_gp   = 20'h0_0010;
  localparam logic [19:0] csr_b_addr_offset_gp   = 20'h0_0018;
  localparam logic [19:0] csr_res_addr_offset_gp = 20'h0_0020;
  localparam logic [19:0] csr_status_offset_gp   = 20'h0_0028;
  localparam logic [19:0] csr_result_offset_gp   = 20'h0_0030;

  function automatic logic mac_busy(input bp_cacc_mac_state_e state);
    return (state != e_mac_idle);
  endfunction

endpackage

// File: rtl/bp_cacc_mac_pipe.sv
// Registered multiply stage feeding a wrapping accumulator. The product is
// truncated to data_width_p bits and added to the accumulator one cycle later.
module bp_cacc_mac_pipe #(
  parameter int data_width_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    v_i,
  input  logic [data_width_p-1:0] a_i,
  input  logic [data_width_p-1:0] b_i,
  output logic                    mul_v_o,
  output logic [data_width_p-1:0] acc_o
);

  logic                    mul_v_q;
  logic [data_width_p-1:0] mul_q;
  logic [data_width_p-1:0] acc_q;
  logic [data_width_p-1:0] prod;

  assign prod = a_i * b_i;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      mul_v_q <= 1'b0;
      mul_q   <= '0;
      acc_q   <= '0;
    end else begin
      mul_v_q <= v_i;
      if (v_i) begin
        mul_q <= prod;
      end
      if (mul_v_q) begin
        acc_q <= acc_q + mul_q;
      end
    end
  end

  assign mul_v_o = mul_v_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/bp_cacc_vdp_mac_stream.sv
// Streaming dot-product engine: job FSM and element counter around the
// multiply/accumulate pipe; one result per job, held until the consumer takes it.
module bp_cacc_vdp_mac_stream
  import bp_cacc_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int len_width_p  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_v_i,
  input  logic [len_width_p-1:0]  start_len_i,
  output logic                    start_ready_o,
  input  logic                    elem_v_i,
  input  logic [data_width_p-1:0] elem_a_i,
  input  logic [data_width_p-1:0] elem_b_i,
  output logic                    elem_ready_o,
  output logic                    res_v_o,
  output logic [data_width_p-1:0] res_o,
  input  logic                    res_yumi_i,
  output logic                    busy_o
);

  bp_cacc_mac_state_e      state_q, state_d;
  logic [len_width_p-1:0]  remaining_q, remaining_d;
  logic                    start_xfer;
  logic                    elem_xfer;
  logic                    acc_clear;
  logic                    mul_v;
  logic [data_width_p-1:0] acc;

  assign start_ready_o = (state_q == e_mac_idle);
  assign elem_ready_o  = (state_q == e_mac_accum) && (remaining_q != '0);
  assign res_v_o       = (state_q == e_mac_done);
  assign busy_o        = mac_busy(state_q);
  assign res_o         = acc;

  assign start_xfer = start_v_i & start_ready_o;
  assign elem_xfer  = elem_v_i & elem_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_mac_idle;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    acc_clear   = 1'b0;
    case (state_q)
      e_mac_idle: begin
        if (start_xfer) begin
          acc_clear = 1'b1;
          if (start_len_i == '0) begin
            state_d = e_mac_done;
          end else begin
            state_d     = e_mac_accum;
            remaining_d = start_len_i;
          end
        end
      end
      e_mac_accum: begin
        if (elem_xfer) begin
          remaining_d = remaining_q - len_width_p'(1);
          // Leave as soon as the last pair is taken so ready drops next cycle.
          if (remaining_q == len_width_p'(1)) begin
            state_d = e_mac_drain;
          end
        end
      end
      e_mac_drain: begin
        if (!mul_v) begin
          state_d = e_mac_done;
        end
      end
      e_mac_done: begin
        if (res_yumi_i) begin
          state_d = e_mac_idle;
        end
      end
      default: begin
        state_d = e_mac_idle;
      end
    endcase
  end

  bp_cacc_mac_pipe #(
    .data_width_p(data_width_p)
  ) u_pipe (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(acc_clear),
    .v_i    (elem_xfer),
    .a_i    (elem_a_i),
    .b_i    (elem_b_i),
    .mul_v_o(mul_v),
    .acc_o  (acc)
  );

endmodule

// File: tb/tb_bp_cacc_vdp_mac_stream.sv
// Bench for the streaming dot-product engine: directed job table, hand-written
// reset/max-length sequences and randomized jobs against a plain-arithmetic model.
module tb_bp_cacc_vdp_mac_stream;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_v_i;
  logic [15:0] start_len_i;
  logic        start_ready_o;
  logic        elem_v_i;
  logic [63:0] elem_a_i;
  logic [63:0] elem_b_i;
  logic        elem_ready_o;
  logic        res_v_o;
  logic [63:0] res_o;
  logic        res_yumi_i;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  logic [63:0] ja [0:15];
  logic [63:0] jb [0:15];

  typedef struct {
    string             name;
    int                len;
    logic [4:0][63:0]  a;
    logic [4:0][63:0]  b;
    bit                gaps;
    bit                poke;
    int                hold;
    logic [63:0]       exp;
  } vec_t;

  vec_t vt [0:4];

  always #5 clk_i = ~clk_i;

  bp_cacc_vdp_mac_stream #(.data_width_p(64), .len_width_p(16)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_v_i    (start_v_i),
    .start_len_i  (start_len_i),
    .start_ready_o(start_ready_o),
    .elem_v_i     (elem_v_i),
    .elem_a_i     (elem_a_i),
    .elem_b_i     (elem_b_i),
    .elem_ready_o (elem_ready_o),
    .res_v_o      (res_v_o),
    .res_o        (res_o),
    .res_yumi_i   (res_yumi_i),
    .busy_o       (busy_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: sum of truncated products, modulo 2^64.
  function automatic logic [63:0] model_dot(input int n);
    logic [63:0] s;
    logic [63:0] p;
    s = '0;
    for (int i = 0; i < n; i++) begin
      p = ja[i] * jb[i];
      s = s + p;
    end
    return s;
  endfunction

  function automatic vec_t mk(input string nm, input int len,
                              input logic [63:0] a0, a1, a2, a3, a4,
                              input logic [63:0] b0, b1, b2, b3, b4,
                              input bit gaps, input bit poke, input int hold,
                              input logic [63:0] exp);
    vec_t v;
    v.name = nm; v.len = len; v.gaps = gaps; v.poke = poke; v.hold = hold; v.exp = exp;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3; v.a[4] = a4;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_job(input string tag, input int len, input bit gaps, input bit poke,
                         input int hold, input logic [63:0] exp);
    int w;
    int idx;
    int cyc;
    int lat;
    bit xfer;
    logic [63:0] held;
    w = 0;
    while (start_ready_o !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk({tag, ".start_wait"}, 64'(w < 50), 64'd1);
    start_v_i   = 1'b1;
    start_len_i = 16'(len);
    tick();
    start_v_i = 1'b0;
    chk({tag, ".busy"}, 64'(busy_o), 64'd1);
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 200) begin
      elem_v_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      elem_a_i = ja[idx];
      elem_b_i = jb[idx];
      if (poke) begin
        start_v_i   = 1'b1;
        start_len_i = 16'd9;
        chk({tag, ".start_ready_in_accum"}, 64'(start_ready_o), 64'd0);
      end
      xfer = elem_v_i && elem_ready_o;
      tick();
      if (xfer) idx++;
      cyc++;
    end
    start_v_i = 1'b0;
    chk({tag, ".feed_done"}, 64'(idx), 64'(len));
    // Keep offering an extra pair; it must never be taken.
    elem_v_i = 1'b1;
    elem_a_i = 64'hDEAD_BEEF_0000_0001;
    elem_b_i = 64'h0000_0000_0000_0101;
    lat = 1;
    while (res_v_o !== 1'b1 && lat < 20) begin
      chk({tag, ".elem_ready_drain"}, 64'(elem_ready_o), 64'd0);
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), (len == 0) ? 64'd1 : 64'd3);
    chk({tag, ".res"}, res_o, exp);
    chk({tag, ".elem_ready_done"}, 64'(elem_ready_o), 64'd0);
    held = res_o;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, ".hold_v"}, 64'(res_v_o), 64'd1);
      chk({tag, ".hold_res"}, res_o, held);
    end
    res_yumi_i = 1'b1;
    tick();
    res_yumi_i = 1'b0;
    elem_v_i   = 1'b0;
    chk({tag, ".post_yumi_v"}, 64'(res_v_o), 64'd0);
    chk({tag, ".post_yumi_ready"}, 64'(start_ready_o), 64'd1);
    chk({tag, ".post_yumi_busy"}, 64'(busy_o), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".start_ready"}, 64'(start_ready_o), 64'd1);
    chk({tag, ".elem_ready"}, 64'(elem_ready_o), 64'd0);
    chk({tag, ".res_v"}, 64'(res_v_o), 64'd0);
    chk({tag, ".res"}, res_o, 64'd0);
    chk({tag, ".busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic [63:0] ones;
    ones = '1;
    vt[0] = mk("t1_len3", 3, 1, 2, 3, 0, 0, 4, 5, 6, 0, 0, 1'b0, 1'b0, 0, 64'd32);
    vt[1] = mk("t2_len0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2, 64'd0);
    vt[2] = mk("t3_ones", 4, ones, ones, ones, ones, 0, ones, ones, ones, ones, 0,
               1'b0, 1'b0, 1, 64'd4);
    vt[3] = mk("t4_gaps", 5, 3, 5, 7, 11, 13, 2, 4, 6, 8, 10, 1'b1, 1'b0, 10, 64'd286);
    vt[4] = mk("t5_poke", 2, 9, 10, 0, 0, 0, 3, 4, 0, 0, 0, 1'b0, 1'b1, 0, 64'd67);

    reset_i     = 1'b1;
    start_v_i   = 1'b0;
    start_len_i = '0;
    elem_v_i    = 1'b0;
    elem_a_i    = '0;
    elem_b_i    = '0;
    res_yumi_i  = 1'b0;
    repeat (2) tick();
    chk_reset_vals("reset");
    reset_i = 1'b0;
    // Elements offered while idle must be ignored.
    elem_v_i = 1'b1;
    elem_a_i = 64'd99;
    elem_b_i = 64'd99;
    tick();
    chk("idle_elem_ready", 64'(elem_ready_o), 64'd0);
    elem_v_i = 1'b0;

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 5; i++) begin
        ja[i] = vt[k].a[i];
        jb[i] = vt[k].b[i];
      end
      run_job(vt[k].name, vt[k].len, vt[k].gaps, vt[k].poke, vt[k].hold, vt[k].exp);
      $display("job %s len=%0d res=%h", vt[k].name, vt[k].len, res_o);
    end

    // Abort a job after two of four pairs.
    start_v_i   = 1'b1;
    start_len_i = 16'd4;
    tick();
    start_v_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      elem_v_i = 1'b1;
      elem_a_i = 64'd100 + 64'(i);
      elem_b_i = 64'd3;
      tick();
    end
    elem_v_i = 1'b0;
    reset_i  = 1'b1;
    tick();
    chk_reset_vals("t6_midreset");
    reset_i = 1'b0;
    ja[0] = 64'd7;
    jb[0] = 64'd6;
    run_job("t6_after_reset", 1, 1'b0, 1'b0, 0, 64'd42);
    $display("job t6_after_reset len=1 res=%h", res_o);

    // Maximum length loads without wrapping the counter.
    start_v_i   = 1'b1;
    start_len_i = 16'hFFFF;
    tick();
    start_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      elem_v_i = 1'b1;
      elem_a_i = 64'd1;
      elem_b_i = 64'd1;
      tick();
    end
    elem_v_i = 1'b0;
    chk("maxlen.elem_ready", 64'(elem_ready_o), 64'd1);
    chk("maxlen.busy", 64'(busy_o), 64'd1);
    chk("maxlen.res_v", 64'(res_v_o), 64'd0);
    $display("job maxlen len=65535 elem_ready=%0b after 3 pairs", elem_ready_o);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;

    for (int r = 0; r < 12; r++) begin
      int len;
      logic [63:0] e;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if (r % 3 == 0) begin
          ja[i] = {$urandom(), $urandom()};
          jb[i] = {$urandom(), $urandom()};
        end else begin
          ja[i] = 64'($urandom_range(0, 1000));
          jb[i] = 64'($urandom_range(0, 1000));
        end
      end
      e = model_dot(len);
      run_job($sformatf("rand%0d", r), len, 1'($urandom_range(0, 1)), 1'b0,
              $urandom_range(0, 4), e);
      $display("job rand%0d len=%0d res=%h", r, len, res_o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
